// File: rtl/mdl_clk2m_arbiter_pkg.sv
// Shared definitions for the 2 MHz subclock halt arbiter.
//   arb_state_t       : arbiter state encoding
//   HOLD_MAX_DEF      : default maximum granted ticks before forced release
//   STOP_TIMEOUT_DEF  : default maximum ticks waiting for the subclock to stop
package mdl_clk2m_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ALIGN     = 3'd1,
    ST_STOPPING  = 3'd2,
    ST_GRANTED   = 3'd3,
    ST_RELEASING = 3'd4
  } arb_state_t;

  localparam logic [7:0] HOLD_MAX_DEF     = 8'd255;
  localparam logic [3:0] STOP_TIMEOUT_DEF = 4'd15;

endpackage

// File: rtl/mdl_clk2m_arbiter_rr2.sv
// submdl_rr2: 2-way round-robin picker with eligibility mask (combinational).
//   req    : raw request levels {REQ1, REQ0}
//   elig   : eligibility mask, 1 = requester may win
//   last   : requester served most recently
//   valid  : at least one eligible requester is asking
//   winner : chosen requester index
module submdl_rr2 (
  input  logic [1:0] req,
  input  logic [1:0] elig,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  logic [1:0] cand;

  assign cand  = req & elig;
  assign valid = |cand;

  always_comb begin
    winner = 1'b0;
    case (cand)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      // Tie: the requester that was not served last goes next.
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mdl_clk2m_arbiter.sv
// mdl_clk2m_arbiter: arbitrates two requesters wanting the 2 MHz subclock
// halted. The winner's stop request is issued to the supervisor aligned to
// rotator slot 4; the grant is given once the delayed stopped status is seen.
// All state advances only on 4 MHz clock-enable ticks.
//   i_MCLK              : master clock (rising edge)
//   i_MRST_n            : asynchronous active-low reset
//   i_CLK4M_PCEN_n      : active-low 4 MHz clock enable (tick)
//   i_ROT8              : one-hot 8-slot rotator
//   i_SYS_RUN_FLAG      : system running
//   i_CLK2M_STOP_DLYD_n : delayed subclock-stopped status, low = stopped
//   i_REQ0/i_REQ1       : halt requests, level, active-high
//   o_GNT0/o_GNT1       : subclock halted for that requester
//   o_CLK2M_STOPRQ0_n/1_n : active-low stop requests to the supervisor
//   o_BUSY              : arbiter not idle
//   o_TIMEOUT           : sticky stop-timeout error
module mdl_clk2m_arbiter
  import mdl_clk2m_arbiter_pkg::*;
#(
  parameter logic [7:0] HOLD_MAX     = HOLD_MAX_DEF,
  parameter logic [3:0] STOP_TIMEOUT = STOP_TIMEOUT_DEF
) (
  input  logic       i_MCLK,
  input  logic       i_MRST_n,
  input  logic       i_CLK4M_PCEN_n,
  input  logic [7:0] i_ROT8,
  input  logic       i_SYS_RUN_FLAG,
  input  logic       i_CLK2M_STOP_DLYD_n,
  input  logic       i_REQ0,
  input  logic       i_REQ1,
  output logic       o_GNT0,
  output logic       o_GNT1,
  output logic       o_CLK2M_STOPRQ0_n,
  output logic       o_CLK2M_STOPRQ1_n,
  output logic       o_BUSY,
  output logic       o_TIMEOUT
);

  arb_state_t state_q, state_nxt;
  logic       win_q, win_nxt;
  logic       last_q, last_nxt;
  logic [1:0] blk_q, blk_nxt;
  logic [3:0] timer_q, timer_nxt;
  logic [7:0] hold_q, hold_nxt;
  logic [1:0] gnt_q, gnt_nxt;
  logic [1:0] rq_n_q, rq_n_nxt;
  logic       busy_q, busy_nxt;
  logic       to_q, to_nxt;

  logic       tick;
  logic [1:0] req;
  logic       req_win;
  logic [3:0] timer_inc;
  logic       pick_vld;
  logic       pick_win;
  logic       force_rel;

  // Only slot 4 marks the alignment point; the other slots are not needed.
  logic       unused_rot;
  assign unused_rot = ^{i_ROT8[7:5], i_ROT8[3:0]};

  assign tick      = ~i_CLK4M_PCEN_n;
  assign req       = {i_REQ1, i_REQ0};
  assign req_win   = req[win_q];
  assign timer_inc = timer_q + 4'd1;

  submdl_rr2 u_rr2 (
    .req    (req),
    .elig   (~blk_q),
    .last   (last_q),
    .valid  (pick_vld),
    .winner (pick_win)
  );

  always_comb begin
    state_nxt = state_q;
    win_nxt   = win_q;
    last_nxt  = last_q;
    blk_nxt   = blk_q;
    timer_nxt = timer_q;
    hold_nxt  = hold_q;
    gnt_nxt   = gnt_q;
    rq_n_nxt  = rq_n_q;
    to_nxt    = to_q;
    force_rel = 1'b0;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (i_SYS_RUN_FLAG && pick_vld) begin
            win_nxt   = pick_win;
            state_nxt = ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (!i_SYS_RUN_FLAG) begin
            force_rel = 1'b1;
            state_nxt = ST_RELEASING;
          end else if (i_ROT8[4]) begin
            rq_n_nxt[win_q] = 1'b0;
            timer_nxt       = 4'd0;
            state_nxt       = ST_STOPPING;
          end
        end
        ST_STOPPING: begin
          timer_nxt = timer_inc;
          if (!i_SYS_RUN_FLAG) begin
            rq_n_nxt  = 2'b11;
            force_rel = 1'b1;
            state_nxt = ST_RELEASING;
          end else if (!i_CLK2M_STOP_DLYD_n) begin
            gnt_nxt[win_q] = 1'b1;
            hold_nxt       = 8'd0;
            state_nxt      = ST_GRANTED;
          end else if (!req_win) begin
            // Requester gave up before the stop was seen: no grant.
            rq_n_nxt  = 2'b11;
            state_nxt = ST_RELEASING;
          end else if (timer_inc == STOP_TIMEOUT) begin
            to_nxt    = 1'b1;
            rq_n_nxt  = 2'b11;
            force_rel = 1'b1;
            state_nxt = ST_RELEASING;
          end
        end
        ST_GRANTED: begin
          hold_nxt = hold_q + 8'd1;
          if (!i_SYS_RUN_FLAG || !req_win || (hold_q == HOLD_MAX)) begin
            gnt_nxt   = 2'b00;
            rq_n_nxt  = 2'b11;
            force_rel = !i_SYS_RUN_FLAG || req_win;
            state_nxt = ST_RELEASING;
          end
        end
        ST_RELEASING: begin
          if (i_CLK2M_STOP_DLYD_n) begin
            last_nxt  = win_q;
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          gnt_nxt   = 2'b00;
          rq_n_nxt  = 2'b11;
          state_nxt = ST_IDLE;
        end
      endcase

      // A forced release blocks the winner until its request is seen low;
      // a low request on this tick lifts the block.
      if (force_rel) blk_nxt[win_q] = 1'b1;
      blk_nxt = blk_nxt & req;
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state_q <= ST_IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      blk_q   <= 2'b00;
      timer_q <= 4'd0;
      hold_q  <= 8'd0;
      gnt_q   <= 2'b00;
      rq_n_q  <= 2'b11;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      win_q   <= win_nxt;
      last_q  <= last_nxt;
      blk_q   <= blk_nxt;
      timer_q <= timer_nxt;
      hold_q  <= hold_nxt;
      gnt_q   <= gnt_nxt;
      rq_n_q  <= rq_n_nxt;
      busy_q  <= busy_nxt;
      to_q    <= to_nxt;
    end
  end

  assign o_GNT0            = gnt_q[0];
  assign o_GNT1            = gnt_q[1];
  assign o_CLK2M_STOPRQ0_n = rq_n_q[0];
  assign o_CLK2M_STOPRQ1_n = rq_n_q[1];
  assign o_BUSY            = busy_q;
  assign o_TIMEOUT         = to_q;

endmodule

// File: tb/tb_mdl_clk2m_arbiter.sv
// Self-checking bench for mdl_clk2m_arbiter (HOLD_MAX=4, STOP_TIMEOUT=15).
module tb_mdl_clk2m_arbiter;

  localparam int TB_HOLD = 4;
  localparam int TB_TO   = 15;

  logic       clk;
  logic       rst_n;
  logic       pcen_n;
  logic [7:0] rot8;
  logic       run;
  logic       stop_n;
  logic       r0, r1;
  logic       o_GNT0, o_GNT1, o_STOPRQ0_n, o_STOPRQ1_n, o_BUSY, o_TIMEOUT;

  int n_chk  = 0;
  int n_fail = 0;

  mdl_clk2m_arbiter #(
    .HOLD_MAX     (8'd4),
    .STOP_TIMEOUT (4'd15)
  ) dut (
    .i_MCLK              (clk),
    .i_MRST_n            (rst_n),
    .i_CLK4M_PCEN_n      (pcen_n),
    .i_ROT8              (rot8),
    .i_SYS_RUN_FLAG      (run),
    .i_CLK2M_STOP_DLYD_n (stop_n),
    .i_REQ0              (r0),
    .i_REQ1              (r1),
    .o_GNT0              (o_GNT0),
    .o_GNT1              (o_GNT1),
    .o_CLK2M_STOPRQ0_n   (o_STOPRQ0_n),
    .o_CLK2M_STOPRQ1_n   (o_STOPRQ1_n),
    .o_BUSY              (o_BUSY),
    .o_TIMEOUT           (o_TIMEOUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  localparam int M_IDLE = 0, M_ALIGN = 1, M_STOP = 2, M_GRANT = 3, M_REL = 4;
  int m_ph, m_who, m_last, m_wait, m_held;
  bit m_blk[2];
  bit m_gnt[2];
  bit m_rq[2];
  bit m_to;

  task automatic model_reset();
    m_ph = M_IDLE; m_who = 0; m_last = 1; m_wait = 0; m_held = 0;
    for (int i = 0; i < 2; i++) begin
      m_blk[i] = 0; m_gnt[i] = 0; m_rq[i] = 0;
    end
    m_to = 0;
  endtask

  task automatic model_drop(input bit block);
    for (int i = 0; i < 2; i++) begin
      m_gnt[i] = 0; m_rq[i] = 0;
    end
    if (block) m_blk[m_who] = 1;
    m_ph = M_REL;
  endtask

  task automatic model_tick();
    bit want[2];
    bit c0, c1;
    want[0] = r0; want[1] = r1;
    if (pcen_n) return;
    case (m_ph)
      M_IDLE: begin
        c0 = want[0] && !m_blk[0];
        c1 = want[1] && !m_blk[1];
        if (run && (c0 || c1)) begin
          if (c0 && c1) m_who = 1 - m_last;
          else          m_who = c1 ? 1 : 0;
          m_ph = M_ALIGN;
        end
      end
      M_ALIGN: begin
        if (!run) model_drop(1);
        else if (rot8[4]) begin
          m_rq[m_who] = 1; m_wait = 0; m_ph = M_STOP;
        end
      end
      M_STOP: begin
        m_wait++;
        if (!run) model_drop(1);
        else if (!stop_n) begin
          m_gnt[m_who] = 1; m_held = 0; m_ph = M_GRANT;
        end else if (!want[m_who]) model_drop(0);
        else if (m_wait == TB_TO) begin
          m_to = 1; model_drop(1);
        end
      end
      M_GRANT: begin
        m_held++;
        if (!run) model_drop(1);
        else if (!want[m_who]) model_drop(0);
        else if (m_held == TB_HOLD + 1) model_drop(1);
      end
      default: begin
        if (stop_n) begin
          m_last = m_who; m_ph = M_IDLE;
        end
      end
    endcase
    for (int i = 0; i < 2; i++) if (!want[i]) m_blk[i] = 0;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_gnt0"},  32'(o_GNT0),      32'(m_gnt[0]));
    chk({tag, "_gnt1"},  32'(o_GNT1),      32'(m_gnt[1]));
    chk({tag, "_rq0n"},  32'(o_STOPRQ0_n), 32'(!m_rq[0]));
    chk({tag, "_rq1n"},  32'(o_STOPRQ1_n), 32'(!m_rq[1]));
    chk({tag, "_busy"},  32'(o_BUSY),      32'(m_ph != M_IDLE));
    chk({tag, "_tmo"},   32'(o_TIMEOUT),   32'(m_to));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Supervisor: stops the subclock one tick after any stop request.
  task automatic sup_update();
    stop_n = o_STOPRQ0_n & o_STOPRQ1_n;
  endtask

  task automatic wait_gnt(input int idx, output int got);
    got = 0;
    for (int c = 0; c < 60; c++) begin
      sup_update();
      cyc();
      if ((idx == 0 && o_GNT0) || (idx == 1 && o_GNT1)) begin
        got = 1;
        break;
      end
    end
  endtask

  typedef struct packed {
    logic pcen_n, rot4, run, stop_n, r0, r1;
    logic g0, g1, q0n, q1n, busy;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int who, got, n, seen;
    pcen_n = 1'b1; rot8 = 8'h01; run = 1'b0; stop_n = 1'b1; r0 = 1'b0; r1 = 1'b0;
    rst_n = 1'b0;

    //                 pc rt rn st r0 r1  g0 g1 q0 q1 by
    tbl[0]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1};
    tbl[1]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1};
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1};
    tbl[3]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1};
    tbl[4]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0};
    tbl[10] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1};
    tbl[12] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1};
    tbl[13] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b1};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1};
    tbl[15] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0};
    tbl[16] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0};

    // Reset values
    do_reset();
    chk("rst_gnt0", 32'(o_GNT0), 0);
    chk("rst_gnt1", 32'(o_GNT1), 0);
    chk("rst_rq0n", 32'(o_STOPRQ0_n), 1);
    chk("rst_rq1n", 32'(o_STOPRQ1_n), 1);
    chk("rst_busy", 32'(o_BUSY), 0);
    chk("rst_tmo",  32'(o_TIMEOUT), 0);

    // Table-driven basic sequence
    for (int i = 0; i < 17; i++) begin
      pcen_n = tbl[i].pcen_n;
      rot8   = tbl[i].rot4 ? 8'h10 : 8'h01;
      run    = tbl[i].run;
      stop_n = tbl[i].stop_n;
      r0     = tbl[i].r0;
      r1     = tbl[i].r1;
      cyc();
      chk($sformatf("tbl%0d_gnt0", i), 32'(o_GNT0),      32'(tbl[i].g0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(o_GNT1),      32'(tbl[i].g1));
      chk($sformatf("tbl%0d_rq0n", i), 32'(o_STOPRQ0_n), 32'(tbl[i].q0n));
      chk($sformatf("tbl%0d_rq1n", i), 32'(o_STOPRQ1_n), 32'(tbl[i].q1n));
      chk($sformatf("tbl%0d_busy", i), 32'(o_BUSY),      32'(tbl[i].busy));
    end

    // Alternation with both requesters asking: 0,1,0,1
    do_reset();
    pcen_n = 1'b0; rot8 = 8'h10; run = 1'b1; r0 = 1'b1; r1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      who = -1;
      for (int c = 0; c < 40 && who < 0; c++) begin
        sup_update();
        cyc();
        if (o_GNT0) who = 0;
        else if (o_GNT1) who = 1;
      end
      chk($sformatf("alt%0d_winner", k), 32'(who), 32'(k % 2));
      if (who == 0) r0 = 1'b0;
      else          r1 = 1'b0;
      for (int c = 0; c < 40 && o_BUSY; c++) begin
        sup_update();
        cyc();
      end
      chk($sformatf("alt%0d_idle", k), 32'(o_BUSY), 0);
      r0 = 1'b1; r1 = 1'b1;
    end

    // Stop timeout: 15 ticks in STOPPING, sticky error, requester blocked
    do_reset();
    pcen_n = 1'b0; rot8 = 8'h10; run = 1'b1; stop_n = 1'b1; r0 = 1'b1; r1 = 1'b0;
    for (int c = 0; c < 20 && o_STOPRQ0_n; c++) cyc();
    chk("to_rq_fell", 32'(o_STOPRQ0_n), 0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      n++;
      if (o_STOPRQ0_n) break;
    end
    chk("to_ticks", 32'(n), 32'(TB_TO));
    chk("to_flag", 32'(o_TIMEOUT), 1);
    repeat (10) cyc();
    chk("to_blocked_idle", 32'(o_BUSY), 0);
    chk("to_sticky", 32'(o_TIMEOUT), 1);
    r0 = 1'b0; cyc();
    r0 = 1'b1; cyc();
    chk("to_unblocked", 32'(o_BUSY), 1);
    chk("to_sticky2", 32'(o_TIMEOUT), 1);
    do_reset();
    chk("to_cleared", 32'(o_TIMEOUT), 0);

    // Hold limit: GNT1 lasts 5 ticks, then requester 1 blocked until toggled
    do_reset();
    pcen_n = 1'b0; rot8 = 8'h10; run = 1'b1; r0 = 1'b0; r1 = 1'b1;
    wait_gnt(1, got);
    chk("hold_first_gnt", 32'(got), 1);
    n = 1;
    for (int c = 0; c < 20; c++) begin
      sup_update();
      cyc();
      if (o_GNT1) n++;
      else break;
    end
    chk("hold_ticks", 32'(n), 32'(TB_HOLD + 1));
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      sup_update();
      cyc();
      if (o_GNT1) seen++;
    end
    chk("hold_no_regrant", 32'(seen), 0);
    chk("hold_idle", 32'(o_BUSY), 0);
    r1 = 1'b0; cyc();
    r1 = 1'b1;
    wait_gnt(1, got);
    chk("hold_regrant", 32'(got), 1);

    // Run flag drop during GRANTED
    do_reset();
    pcen_n = 1'b0; rot8 = 8'h10; run = 1'b1; r0 = 1'b1; r1 = 1'b0;
    wait_gnt(0, got);
    chk("abort_gnt", 32'(got), 1);
    run = 1'b0;
    cyc();
    chk("abort_gnt0", 32'(o_GNT0), 0);
    chk("abort_rq0n", 32'(o_STOPRQ0_n), 1);
    chk("abort_busy", 32'(o_BUSY), 1);
    cyc();
    chk("abort_rel_hold", 32'(o_BUSY), 1);
    stop_n = 1'b1;
    cyc();
    chk("abort_idle", 32'(o_BUSY), 0);
    run = 1'b1;

    // Asynchronous reset during GRANTED
    do_reset();
    pcen_n = 1'b0; rot8 = 8'h10; run = 1'b1; r0 = 1'b1; r1 = 1'b0;
    wait_gnt(0, got);
    chk("arst_gnt", 32'(got), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt0", 32'(o_GNT0), 0);
    chk("arst_rq0n", 32'(o_STOPRQ0_n), 1);
    chk("arst_busy", 32'(o_BUSY), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      pcen_n = ($urandom_range(0, 3) == 0);
      rot8   = 8'h01 << $urandom_range(0, 7);
      run    = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 11) == 0) r0 = ~r0;
      if ($urandom_range(0, 11) == 0) r1 = ~r1;
      if ((i / 300) % 3 == 2)            stop_n = 1'b1;
      else if ($urandom_range(0, 7) == 0) stop_n = ~stop_n;
      else                                sup_update();
      cyc();
      cmp_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
